// File: rtl/dispatch_pkg.sv
// Shared types and default sizing for the two-lane dispatch allocator.
package dispatch_pkg;

  localparam int unsigned ROB_DEPTH = 8;
  localparam int unsigned TAG_W     = 3;
  localparam int unsigned RS_DEPTH  = 4;

  typedef enum logic [1:0] {
    OP_ADD    = 2'b00,
    OP_MUL    = 2'b01,
    OP_BRANCH = 2'b10,
    OP_NOP    = 2'b11
  } op_type_t;

  // Encodings kept identical to the legacy arbiter's state register.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    GRANT = ST_GRANT,
    STALL = ST_STALL
  } arb_state_t;

endpackage

// File: rtl/rs_slot_picker.sv
// Combinational picker: lowest and second-lowest free entries of a
// reservation-station availability mask.
module rs_slot_picker #(
  parameter int unsigned DEPTH = dispatch_pkg::RS_DEPTH
) (
  input  logic [DEPTH-1:0]         avail,
  output logic [$clog2(DEPTH)-1:0] first_idx,
  output logic                     first_vld,
  output logic [$clog2(DEPTH)-1:0] second_idx,
  output logic                     second_vld
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  always_comb begin
    first_idx  = '0;
    first_vld  = 1'b0;
    second_idx = '0;
    second_vld = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (avail[i]) begin
        if (!first_vld) begin
          first_vld = 1'b1;
          first_idx = IDX_W'(i);
        end else if (!second_vld) begin
          second_vld = 1'b1;
          second_idx = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/dispatch_alloc_arbiter.sv
// Two-lane in-order dispatch allocator: ROB tag and RS entry assignment with
// a registered grant. STALL_CNT_EN builds the stall-cycle performance counter.
module dispatch_alloc_arbiter #(
  parameter int unsigned ROB_DEPTH = dispatch_pkg::ROB_DEPTH,
  parameter int unsigned TAG_W     = dispatch_pkg::TAG_W,
  parameter int unsigned RS_DEPTH  = dispatch_pkg::RS_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req0_valid,
  input  logic [1:0]                  req0_type,
  input  logic                        req1_valid,
  input  logic [1:0]                  req1_type,
  input  logic [RS_DEPTH-1:0]         add_avail,
  input  logic [RS_DEPTH-1:0]         mul_avail,
  input  logic [1:0]                  commit_cnt,
  input  logic                        flush,
  output logic                        grant0,
  output logic                        grant1,
  output logic [TAG_W-1:0]            tag0,
  output logic [TAG_W-1:0]            tag1,
  output logic [$clog2(RS_DEPTH)-1:0] rs_id0,
  output logic [$clog2(RS_DEPTH)-1:0] rs_id1,
  output logic                        alloc0,
  output logic                        alloc1,
  output logic [TAG_W:0]              rob_count,
  output logic                        stall,
  output logic [15:0]                 perf_stall_cycles
);

  import dispatch_pkg::*;

  localparam int unsigned RS_W  = $clog2(RS_DEPTH);
  localparam int unsigned CNT_W = TAG_W + 1;

  op_type_t t0, t1;
  assign t0 = op_type_t'(req0_type);
  assign t1 = op_type_t'(req1_type);

  logic [RS_W-1:0] add_first_idx, add_second_idx, mul_first_idx, mul_second_idx;
  logic            add_first_vld, add_second_vld, mul_first_vld, mul_second_vld;

  rs_slot_picker #(.DEPTH(RS_DEPTH)) u_add_pick (
    .avail      (add_avail),
    .first_idx  (add_first_idx),
    .first_vld  (add_first_vld),
    .second_idx (add_second_idx),
    .second_vld (add_second_vld)
  );

  rs_slot_picker #(.DEPTH(RS_DEPTH)) u_mul_pick (
    .avail      (mul_avail),
    .first_idx  (mul_first_idx),
    .first_vld  (mul_first_vld),
    .second_idx (mul_second_idx),
    .second_vld (mul_second_vld)
  );

  arb_state_t       state_q, state_d;
  logic             grant0_q, grant0_d, grant1_q, grant1_d;
  logic [TAG_W-1:0] tag0_q, tag0_d, tag1_q, tag1_d;
  logic [RS_W-1:0]  rs_id0_q, rs_id0_d, rs_id1_q, rs_id1_d;
  logic             alloc0_q, alloc0_d, alloc1_q, alloc1_d;
  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] rob_count_q, rob_count_d;
  logic             stall_q, stall_d;

  logic [CNT_W-1:0] free_slots;
  logic             need0, need1, res0, res1, ok0, ok1, a0, a1;
  logic [RS_W-1:0]  rs0, rs1;

  // Lane eligibility; a second same-type request takes the picker's second slot.
  always_comb begin
    free_slots = CNT_W'(ROB_DEPTH) - rob_count_q;
    need0      = (t0 != OP_NOP);
    need1      = (t1 != OP_NOP);
    res0       = 1'b1;
    rs0        = '0;
    case (t0)
      OP_ADD:  begin res0 = add_first_vld; rs0 = add_first_idx; end
      OP_MUL:  begin res0 = mul_first_vld; rs0 = mul_first_idx; end
      default: ;
    endcase
    ok0  = req0_valid && res0 && (!need0 || (free_slots != '0));
    res1 = 1'b1;
    rs1  = '0;
    case (t1)
      OP_ADD: begin
        if (ok0 && t0 == OP_ADD) begin res1 = add_second_vld; rs1 = add_second_idx; end
        else                     begin res1 = add_first_vld;  rs1 = add_first_idx;  end
      end
      OP_MUL: begin
        if (ok0 && t0 == OP_MUL) begin res1 = mul_second_vld; rs1 = mul_second_idx; end
        else                     begin res1 = mul_first_vld;  rs1 = mul_first_idx;  end
      end
      default: ;
    endcase
    ok1 = req1_valid && (ok0 || !req0_valid) && res1 &&
          (!need1 || (free_slots > ((ok0 && need0) ? CNT_W'(1) : CNT_W'(0))));
    a0  = ok0 && need0;
    a1  = ok1 && need1;
  end

  always_comb begin
    state_d     = state_q;
    grant0_d    = 1'b0;
    grant1_d    = 1'b0;
    tag0_d      = '0;
    tag1_d      = '0;
    rs_id0_d    = '0;
    rs_id1_d    = '0;
    alloc0_d    = 1'b0;
    alloc1_d    = 1'b0;
    stall_d     = 1'b0;
    head_d      = head_q + TAG_W'(commit_cnt);
    tail_d      = tail_q;
    rob_count_d = rob_count_q - CNT_W'(commit_cnt);
    if (flush) begin
      state_d     = IDLE;
      tail_d      = head_q + TAG_W'(commit_cnt);
      rob_count_d = '0;
    end else if (state_q == GRANT) begin
      state_d = IDLE;
    end else if (ok0 || ok1) begin
      state_d     = GRANT;
      grant0_d    = ok0;
      grant1_d    = ok1;
      alloc0_d    = a0;
      alloc1_d    = a1;
      tag0_d      = a0 ? tail_q : '0;
      tag1_d      = a1 ? (a0 ? tail_q + TAG_W'(1) : tail_q) : '0;
      rs_id0_d    = ok0 ? rs0 : '0;
      rs_id1_d    = ok1 ? rs1 : '0;
      tail_d      = tail_q + TAG_W'(a0) + TAG_W'(a1);
      rob_count_d = rob_count_q + CNT_W'(a0) + CNT_W'(a1) - CNT_W'(commit_cnt);
    end else if (req0_valid || req1_valid) begin
      state_d = STALL;
      stall_d = 1'b1;
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant0_q    <= 1'b0;
      grant1_q    <= 1'b0;
      tag0_q      <= '0;
      tag1_q      <= '0;
      rs_id0_q    <= '0;
      rs_id1_q    <= '0;
      alloc0_q    <= 1'b0;
      alloc1_q    <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      rob_count_q <= '0;
      stall_q     <= 1'b0;
    end else begin
      assert (CNT_W'(commit_cnt) <= rob_count_q)
        else $error("commit_cnt %0d exceeds rob_count %0d", commit_cnt, rob_count_q);
      state_q     <= state_d;
      grant0_q    <= grant0_d;
      grant1_q    <= grant1_d;
      tag0_q      <= tag0_d;
      tag1_q      <= tag1_d;
      rs_id0_q    <= rs_id0_d;
      rs_id1_q    <= rs_id1_d;
      alloc0_q    <= alloc0_d;
      alloc1_q    <= alloc1_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      rob_count_q <= rob_count_d;
      stall_q     <= stall_d;
    end
  end

  assign grant0    = grant0_q;
  assign grant1    = grant1_q;
  assign tag0      = tag0_q;
  assign tag1      = tag1_q;
  assign rs_id0    = rs_id0_q;
  assign rs_id1    = rs_id1_q;
  assign alloc0    = alloc0_q;
  assign alloc1    = alloc1_q;
  assign rob_count = rob_count_q;
  assign stall     = stall_q;

`ifdef STALL_CNT_EN
  logic [15:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (stall_q && (perf_q != '1)) perf_d = perf_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign perf_stall_cycles = perf_q;
`else
  assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_dispatch_alloc_arbiter.sv
// Scoreboard bench for dispatch_alloc_arbiter: expected grants are queued as
// requests are driven and compared when the grant pulse appears.
module tb_dispatch_alloc_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [1:0] req0_type, req1_type;
  logic [3:0] add_avail, mul_avail;
  logic [1:0] commit_cnt;
  logic       flush;
  logic       grant0, grant1, alloc0, alloc1, stall;
  logic [2:0] tag0, tag1;
  logic [1:0] rs_id0, rs_id1;
  logic [3:0] rob_count;
  logic [15:0] perf_stall_cycles;

  always #5 clk = ~clk;

  dispatch_alloc_arbiter #(.ROB_DEPTH(8), .TAG_W(3), .RS_DEPTH(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .req0_valid        (req0_valid),
    .req0_type         (req0_type),
    .req1_valid        (req1_valid),
    .req1_type         (req1_type),
    .add_avail         (add_avail),
    .mul_avail         (mul_avail),
    .commit_cnt        (commit_cnt),
    .flush             (flush),
    .grant0            (grant0),
    .grant1            (grant1),
    .tag0              (tag0),
    .tag1              (tag1),
    .rs_id0            (rs_id0),
    .rs_id1            (rs_id1),
    .alloc0            (alloc0),
    .alloc1            (alloc1),
    .rob_count         (rob_count),
    .stall             (stall),
    .perf_stall_cycles (perf_stall_cycles)
  );

  localparam logic [1:0] T_ADD = 2'b00, T_MUL = 2'b01, T_BR = 2'b10, T_NOP = 2'b11;

  typedef struct packed {
    logic       g0, g1;
    logic [2:0] t0, t1;
    logic [1:0] r0, r1;
    logic       a0, a1;
    logic [3:0] cnt;
  } gnt_t;

  gnt_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_head, m_tail, m_cnt;

  function automatic gnt_t observe();
    gnt_t o;
    o.g0 = grant0; o.g1 = grant1; o.t0 = tag0; o.t1 = tag1;
    o.r0 = rs_id0; o.r1 = rs_id1; o.a0 = alloc0; o.a1 = alloc1;
    o.cnt = rob_count;
    return o;
  endfunction

  // Expected tags follow the ROB tail model: lane 0 takes tail, lane 1 the next.
  task automatic push(input logic g0, g1, a0, a1, input logic [1:0] r0, r1);
    gnt_t e;
    e.g0 = g0; e.g1 = g1; e.a0 = a0; e.a1 = a1; e.r0 = r0; e.r1 = r1;
    e.t0 = a0 ? 3'(m_tail) : 3'd0;
    e.t1 = a1 ? 3'((m_tail + (a0 ? 1 : 0)) % 8) : 3'd0;
    m_tail = (m_tail + (a0 ? 1 : 0) + (a1 ? 1 : 0)) % 8;
    m_cnt  = m_cnt + (a0 ? 1 : 0) + (a1 ? 1 : 0);
    e.cnt  = 4'(m_cnt);
    sb.push_back(e);
  endtask

  task automatic wait_grant(output gnt_t obs);
    obs = '0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); @(negedge clk);
      if (grant0 || grant1) begin
        obs = observe();
        return;
      end
    end
  endtask

  task automatic commit(input int n);
    commit_cnt = 2'(n);
    @(posedge clk); @(negedge clk);
    commit_cnt = 2'd0;
    m_cnt  = m_cnt - n;
    m_head = (m_head + n) % 8;
  endtask

  task automatic do_reset();
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_type = T_NOP; req1_type = T_NOP;
    add_avail = 4'b1111; mul_avail = 4'b1111; commit_cnt = 2'd0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_head = 0; m_tail = 0; m_cnt = 0;
    sb.delete();
  endtask

  task automatic test_reset();
    gnt_t o;
    o = observe();
    n_checks++;
    if (o !== gnt_t'('0)) $display("FAIL reset_outputs: got %h expected 0", o); else n_pass++;
    n_checks++;
    if (stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall); else n_pass++;
    n_checks++;
    if (perf_stall_cycles !== 16'd0) $display("FAIL reset_perf: got %0d expected 0", perf_stall_cycles); else n_pass++;
  endtask

  task automatic test_dual();
    gnt_t o, e;
    add_avail = 4'b1111; mul_avail = 4'b1111;
    req0_valid = 1'b1; req0_type = T_ADD; req1_valid = 1'b1; req1_type = T_MUL;
    push(1, 1, 1, 1, 2'd0, 2'd0);
    wait_grant(o);
    req0_valid = 1'b0; req1_valid = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (o !== e) $display("FAIL dual_grant: got %h expected %h", o, e); else n_pass++;
    commit(2);
    n_checks++;
    if (rob_count !== 4'(m_cnt)) $display("FAIL dual_commit: got %0d expected %0d", rob_count, m_cnt); else n_pass++;
  endtask

  task automatic test_rs_second();
    gnt_t o, e;
    add_avail = 4'b0100;
    req0_valid = 1'b1; req0_type = T_ADD; req1_valid = 1'b1; req1_type = T_ADD;
    push(1, 0, 1, 0, 2'd2, 2'd0);
    wait_grant(o);
    req0_valid = 1'b0; add_avail = 4'b0000;
    e = sb.pop_front();
    n_checks++;
    if (o !== e) $display("FAIL rs_single_slot: got %h expected %h", o, e); else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({stall, grant1} !== 2'b10) $display("FAIL rs_wait_stall: got stall,grant1=%b expected 10", {stall, grant1}); else n_pass++;
    add_avail = 4'b1000;
    push(0, 1, 0, 1, 2'd0, 2'd3);
    wait_grant(o);
    req1_valid = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (o !== e) $display("FAIL rs_lane1_regrant: got %h expected %h", o, e); else n_pass++;
    commit(2);
  endtask

  task automatic test_rob_wrap();
    gnt_t o, e;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      req0_valid = 1'b1; req0_type = T_BR;
      req1_valid = (k < 3); req1_type = T_BR;
      push(1, k < 3, 1, k < 3, 2'd0, 2'd0);
      wait_grant(o);
      req0_valid = 1'b0; req1_valid = 1'b0;
      e = sb.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL fill_branch%0d: got %h expected %h", k, o, e); else n_pass++;
    end
    add_avail = 4'b1111;
    req0_valid = 1'b1; req0_type = T_ADD; req1_valid = 1'b1; req1_type = T_ADD;
    push(1, 0, 1, 0, 2'd0, 2'd0);
    wait_grant(o);
    req0_valid = 1'b0; add_avail = 4'b1110;
    e = sb.pop_front();
    n_checks++;
    if (o !== e) $display("FAIL rob_last_slot: got %h expected %h", o, e); else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({stall, grant1} !== 2'b10) $display("FAIL rob_full_stall: got stall,grant1=%b expected 10", {stall, grant1}); else n_pass++;
    commit(1);
    push(0, 1, 0, 1, 2'd0, 2'd1);
    wait_grant(o);
    req1_valid = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (o !== e) $display("FAIL rob_tag_wrap: got %h expected %h", o, e); else n_pass++;
    repeat (4) commit(2);
    n_checks++;
    if (rob_count !== 4'(m_cnt)) $display("FAIL rob_drain: got %0d expected %0d", rob_count, m_cnt); else n_pass++;
  endtask

  task automatic test_order_stall();
    gnt_t o, e;
    add_avail = 4'b1111; mul_avail = 4'b0000;
    req0_valid = 1'b1; req0_type = T_MUL; req1_valid = 1'b1; req1_type = T_ADD;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      n_checks++;
      if ({grant0, grant1} !== 2'b00) $display("FAIL order_no_skip%0d: got grants=%b expected 00", i, {grant0, grant1}); else n_pass++;
    end
    n_checks++;
    if (stall !== 1'b1) $display("FAIL order_stall: got %b expected 1", stall); else n_pass++;
    mul_avail = 4'b0010;
    push(1, 1, 1, 1, 2'd1, 2'd0);
    wait_grant(o);
    req0_valid = 1'b0; req1_valid = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (o !== e) $display("FAIL order_release: got %h expected %h", o, e); else n_pass++;
    commit(2);
  endtask

  task automatic test_flush();
    gnt_t o, e;
    for (int k = 0; k < 3; k++) begin
      req0_valid = 1'b1; req0_type = T_BR;
      req1_valid = (k < 2); req1_type = T_BR;
      push(1, k < 2, 1, k < 2, 2'd0, 2'd0);
      wait_grant(o);
      req0_valid = 1'b0; req1_valid = 1'b0;
      e = sb.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL flush_fill%0d: got %h expected %h", k, o, e); else n_pass++;
    end
    add_avail = 4'b1111;
    req0_valid = 1'b1; req0_type = T_ADD; req1_valid = 1'b1; req1_type = T_ADD;
    commit_cnt = 2'd2; flush = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0; commit_cnt = 2'd0; req0_valid = 1'b0; req1_valid = 1'b0;
    m_head = (m_head + 2) % 8; m_tail = m_head; m_cnt = 0;
    n_checks++;
    if ({grant0, grant1, rob_count} !== 6'd0) $display("FAIL flush_state: got grants,count=%b expected 0", {grant0, grant1, rob_count}); else n_pass++;
    req0_valid = 1'b1; req0_type = T_BR;
    push(1, 0, 1, 0, 2'd0, 2'd0);
    wait_grant(o);
    req0_valid = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (o !== e) $display("FAIL flush_tail: got %h expected %h", o, e); else n_pass++;
    commit(1);
  endtask

  task automatic test_nop();
    gnt_t o, e;
    req0_valid = 1'b1; req0_type = T_NOP; req1_valid = 1'b1; req1_type = T_BR;
    push(1, 1, 0, 1, 2'd0, 2'd0);
    wait_grant(o);
    req1_type = T_NOP;
    e = sb.pop_front();
    n_checks++;
    if (o !== e) $display("FAIL nop_branch: got %h expected %h", o, e); else n_pass++;
    push(1, 1, 0, 0, 2'd0, 2'd0);
    wait_grant(o);
    req0_valid = 1'b0; req1_valid = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (o !== e) $display("FAIL nop_pair: got %h expected %h", o, e); else n_pass++;
    commit(1);
  endtask

  task automatic test_perf();
    logic [15:0] exp_perf;
    do_reset();
    mul_avail = 4'b0000;
    req0_valid = 1'b1; req0_type = T_MUL;
    repeat (20) @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
`ifdef STALL_CNT_EN
    exp_perf = 16'd20;
`else
    exp_perf = 16'd0;
`endif
    n_checks++;
    if (perf_stall_cycles !== exp_perf) $display("FAIL perf_count: got %0d expected %0d", perf_stall_cycles, exp_perf); else n_pass++;
    n_checks++;
    if (stall !== 1'b0) $display("FAIL perf_stall_clear: got %b expected 0", stall); else n_pass++;
  endtask

  initial begin
    do_reset();
    test_reset();
    test_dual();
    test_rs_second();
    test_rob_wrap();
    test_order_stall();
    test_flush();
    test_nop();
    test_perf();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/dispatch_alloc_arbiter.md
Name: dispatch_alloc_arbiter

Overview:
- Central allocator shared by the two dispatch lanes (lane 0 = older instruction, lane 1 = younger).
- Each cycle it decides, in program order, which lanes may dispatch. It assigns ROB tags from its own tail/count tracking and picks reservation-station entry IDs from the ADD/MUL availability masks.
- Sits between the dispatch units and RAT/RS/ROB; replaces per-lane hazard checking with a single registered grant.

Parameters:
- ROB_DEPTH, 8, number of ROB entries (power of two).
- TAG_W, 3, ROB tag width, log2(ROB_DEPTH).
- RS_DEPTH, 4, entries per reservation station (ADD and MUL each).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- req0_valid  in  1  lane 0 request; held until grant0.
- req0_type  in  2  00 ADD, 01 MUL, 10 BRANCH, 11 NOP.
- req1_valid  in  1  lane 1 request; held until grant1.
- req1_type  in  2  as req0_type.
- add_avail  in  RS_DEPTH  free-entry mask, ADD RS (1 = free).
- mul_avail  in  RS_DEPTH  free-entry mask, MUL RS.
- commit_cnt  in  2  ROB entries retired this cycle (0..2).
- flush  in  1  mispredict squash of all uncommitted entries.
- grant0, grant1  out  1  single-cycle grant pulses.
- tag0, tag1  out  TAG_W  ROB tag for each granted lane.
- rs_id0, rs_id1  out  log2(RS_DEPTH)  RS entry index (don't-care for BRANCH/NOP).
- alloc0, alloc1  out  1  granted lane consumed a ROB entry (ADD/MUL/BRANCH).
- rob_count  out  TAG_W+1  occupied ROB entries.
- stall  out  1  a valid request exists that cannot be granted this cycle.
- perf_stall_cycles  out  16  see Optional Feature.

Behaviour:
- Reset: all outputs 0; head=tail=0; rob_count=0; state IDLE.
- FSM states: IDLE, GRANT, STALL.
  - IDLE/STALL: evaluate requests.
    - If at least one lane is grantable, go to GRANT.
    - Else if any req valid, go to (or stay in) STALL with stall=1.
    - Else go to IDLE.
  - GRANT: grants pulse for exactly this one cycle; requests are ignored. This masks stale avail bits while the RS absorbs the new entries. Always return to IDLE.
- Grant outputs are registered: decision in cycle N, grant/tag/rs_id valid in cycle N+1; minimum 2 cycles between grants to the same lane.
- Order rule: lane 1 may be granted only if lane 0 is granted in the same decision or req0_valid=0. Lane 0 is never skipped.
- Resources:
  - ADD/MUL need 1 RS entry of that type plus 1 ROB entry.
  - BRANCH needs 1 ROB entry only.
  - NOP needs nothing; granted with alloc=0 and tag=0.
- RS pick: lowest-index free bit for the first same-type request. The second same-type request gets the next lowest free bit; if none, it is not granted.
- ROB pick: tag0 = tail. tag1 = tail if lane 0 did not allocate, else tail+1 (mod ROB_DEPTH). Free space = ROB_DEPTH - rob_count. Commits in the decision cycle are not credited until the next cycle.
- Counter update: rob_count += allocs - commit_cnt.
  - head += commit_cnt; tail += allocs; both wrap mod ROB_DEPTH.
  - A simultaneous commit and allocate both apply.
  - commit_cnt > rob_count is illegal (assertion).
- flush: priority below reset, above everything else.
  - tail <= head + commit_cnt; rob_count <= 0.
  - Grants forced 0 that cycle; state <= IDLE.
  - Pending requests are dropped by the lanes.
- Full boundary: rob_count=ROB_DEPTH means no allocating grant. rob_count=ROB_DEPTH-1 means only the older allocating lane can be granted.

Optional Feature:
- STALL_CNT_EN defined: perf_stall_cycles increments each cycle stall=1, saturates at 16'hFFFF, and clears on reset only.
- Undefined: the counter is not built and perf_stall_cycles is tied to 0.

Decomposition:
- dispatch_pkg holds:
  - op_type_t enum (OP_ADD, OP_MUL, OP_BRANCH, OP_NOP);
  - ROB_DEPTH, TAG_W, RS_DEPTH constants;
  - the arb_state_t enum.
- Sub-module rs_slot_picker: combinational; mask in, first and second free index plus valid flags out. Instantiated once per RS type.

Test Plan:
- Reset, then req0=ADD, req1=MUL, all masks 4'b1111 -> one cycle later grant0=grant1=1, tag0=0, tag1=1, rs_id0=0, rs_id1=0, rob_count=2.
- Two ADD requests with add_avail=4'b0100 -> grant0 only, rs_id0=2; lane 1 granted on re-request once its bit frees.
- rob_count=7, two ADD requests -> grant0 only, tag0=7; next grant tag wraps to 0 after one commit.
- req0 MUL with mul_avail=0 and req1 ADD with free space -> neither granted, stall=1 until mul_avail≠0 (order preserved).
- rob_count=5, commit_cnt=2 and flush in the same cycle -> rob_count=0, tail=head+2, no grants.
- With STALL_CNT_EN, hold a blocked request for 20 cycles -> perf_stall_cycles=20; without the macro it stays 0.
